hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline. Drives enable and flush for the IF_ID, ID_EX, EX_MEM and MEM_WB latches, and the PC enable.
- Inputs: cache hit signals, load-use operands, branch/jump redirects and the WB-stage halt.
- Sequences the halt drain (dcache flush, then halt).
- Keeps a saturating stall-cycle counter for performance visibility.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.
- REG_W, 5, register-select width (regbits_t).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- ihit  in  1  icache returned the instruction this cycle.
- imemREN  in  1  fetch request active.
- dhit  in  1  dcache completed the MEM-stage access this cycle.
- dmemREN_mem  in  1  load in MEM.
- dmemWEN_mem  in  1  store in MEM.
- memread_ex  in  1  instruction in EX is a load.
- rt_ex  in  REG_W  destination of the EX-stage load.
- rs_id  in  REG_W  ID-stage source register.
- rt_id  in  REG_W  ID-stage source register.
- branch_taken_ex  in  1  branch resolved taken in EX.
- jump_id  in  1  J/JAL/JR decoded in ID.
- halt_wb  in  1  halt_out of the MEM_WB latch.
- flush_done  in  1  dcache writeback complete.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF_ID latch enable.
- idex_en  out  1  ID_EX latch enable.
- exmem_en  out  1  EX_MEM latch enable.
- memwb_en  out  1  MEM_WB latch enable.
- ifid_flush  out  1  IF_ID latch clear (bubble).
- idex_flush  out  1  ID_EX latch clear.
- exmem_flush  out  1  EX_MEM latch clear.
- memwb_flush  out  1  MEM_WB latch clear.
- dcache_flush  out  1  request dcache writeback.
- halt  out  1  CPU halted (sticky).
- stall_count  out  CNT_W  cycles with pc_en=0 in RUN/DSTALL.

Behaviour:
- FSM states: RUN, DSTALL, HFLUSH, HALTED. Register only the state, the counter and halt; all other outputs are combinational from the state and inputs.
- Flush has priority over enable at the latch: flush=1 loads the latch's reset values on the next edge.
- Reset (sync, RST=1 at the edge) from any state, including mid-DSTALL or mid-HFLUSH:
  - state=RUN, stall_count=0, halt=0.
  - While RST is high, all enables=0, all flushes=1, dcache_flush=0.
- dmiss = (dmemREN_mem | dmemWEN_mem) & ~dhit.
- loaduse = memread_ex & (rt_ex!=0) & (rt_ex==rs_id | rt_ex==rt_id).
- RUN decisions, first match wins; unnamed enables=1, unnamed flushes=0:
  1. halt_wb: next=HFLUSH. All enables=0, memwb_flush=1.
  2. dmiss: next=DSTALL. pc_en, ifid_en, idex_en, exmem_en=0; memwb_flush=1 so WB does not re-execute.
  3. branch_taken_ex: ifid_flush=1, idex_flush=1, pc_en=1 (target load). A coincident loaduse or imiss is ignored.
  4. loaduse: pc_en=0, ifid_en=0, idex_flush=1.
  5. jump_id: ifid_flush=1, pc_en=1.
  6. imemREN & ~ihit: pc_en=0, ifid_flush=1.
- DSTALL:
  - While ~dhit: same outputs as RUN rule 2.
  - On dhit: evaluate RUN rules 3–6 for this cycle (the pipeline advances) and set next=RUN.
  - halt_wb cannot be asserted here, because MEM_WB holds a bubble.
- HFLUSH:
  - All enables=0, flushes=0, dcache_flush=1.
  - On flush_done: next=HALTED; halt=1 from the following cycle.
- HALTED:
  - All enables=0, dcache_flush=0, halt=1.
  - Leave only on RST.
- stall_count: +1 on every edge where state∈{RUN,DSTALL}, rule 1 did not fire, and pc_en=0. Saturates at 2^CNT_W−1 (no wrap).
- Latency: all stall/flush responses take effect in the same cycle as the triggering input. State changes take one cycle.

Decomposition:
- Shared package (cpu_types_pkg) holds the `hzstate_t` enum {RUN, DSTALL, HFLUSH, HALTED} and `regbits_t`.
- Sub-module `stall_counter` (parameter CNT_W; inputs CLK, RST, inc; output count) implements the saturating increment.
- The rest is one always_ff for state/halt plus one always_comb priority block.

Test Plan:
- memread_ex=1, rt_ex=5, rs_id=5, all hits → for that cycle pc_en=0, ifid_en=0, idex_flush=1, others advance; stall_count 0→1. Repeat with rt_ex=0 → no stall, count unchanged.
- dmemREN_mem=1, dhit=0 for 3 cycles then 1 → state DSTALL for 3 cycles, pc/ifid/idex/exmem_en=0 and memwb_flush=1 each cycle; on the dhit cycle all enables=1; state RUN; stall_count=3.
- branch_taken_ex=1 with loaduse true and ihit=0 same cycle → ifid_flush=1, idex_flush=1, pc_en=1, stall_count unchanged.
- halt_wb=1 → HFLUSH next cycle with dcache_flush=1 and all enables=0; flush_done after 4 cycles → HALTED, halt=1 held for 10+ cycles. Repeat, asserting RST on the 2nd HFLUSH cycle → state RUN, halt=0, stall_count=0.
- CNT_W=4, imemREN=1, ihit=0 for 20 cycles → pc_en=0 and ifid_flush=1 each cycle; stall_count saturates at 15.
- jump_id=1 with dmiss same cycle → dmiss wins (DSTALL); after dhit, with jump_id still 1 → ifid_flush=1, pc_en=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard FSM state encoding
// and register-select width.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DSTALL,
        HFLUSH,
        HALTED
    } hzstate_t;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard control bundle: pipeline status in, latch
// enables/flushes, dcache flush, halt and stall count out.
interface hazard_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
);
    logic             ihit;
    logic             imemREN;
    logic             dhit;
    logic             dmemREN_mem;
    logic             dmemWEN_mem;
    logic             memread_ex;
    logic [REG_W-1:0] rt_ex;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             branch_taken_ex;
    logic             jump_id;
    logic             halt_wb;
    logic             flush_done;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             dcache_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: drives status, receives controls.
    modport master (
        output ihit, imemREN, dhit, dmemREN_mem, dmemWEN_mem,
        output memread_ex, rt_ex, rs_id, rt_id,
        output branch_taken_ex, jump_id, halt_wb, flush_done,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  dcache_flush, halt, stall_count
    );

    // Sequencer side.
    modport slave (
        input  ihit, imemREN, dhit, dmemREN_mem, dmemWEN_mem,
        input  memread_ex, rt_ex, rs_id, rt_id,
        input  branch_taken_ex, jump_id, halt_wb, flush_done,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output dcache_flush, halt, stall_count
    );

endinterface

// File: rtl/stall_counter.sv
// Saturating cycle counter (CLK, RST sync high, inc in,
// count out); holds at all-ones instead of wrapping.
module stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush controller and halt drain sequencer.
// Ports: CLK, RST (sync high), bus (hazard_sequencer_if.slave).
module hazard_sequencer
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input logic CLK,
    input logic RST,
    hazard_sequencer_if.slave bus
);

    hzstate_t         r_state;
    hzstate_t         w_next;
    logic             r_halt;
    logic [REG_W-1:0] w_rt_ex;
    logic             w_dmiss;
    logic             w_loaduse;
    logic             w_run;
    logic             w_r1;
    logic             w_inc;
    logic             w_pc, w_ifid, w_idex, w_exmem, w_memwb;
    logic             w_fifid, w_fidex, w_fexmem, w_fmemwb;
    logic             w_dcf;

    assign w_rt_ex   = bus.rt_ex;
    assign w_dmiss   = (bus.dmemREN_mem | bus.dmemWEN_mem)
                     & ~bus.dhit;
    assign w_loaduse = bus.memread_ex & (w_rt_ex != '0)
                     & ((w_rt_ex == bus.rs_id)
                     |  (w_rt_ex == bus.rt_id));

    always_comb begin
        w_next   = r_state;
        w_pc     = 1'b1;
        w_ifid   = 1'b1;
        w_idex   = 1'b1;
        w_exmem  = 1'b1;
        w_memwb  = 1'b1;
        w_fifid  = 1'b0;
        w_fidex  = 1'b0;
        w_fexmem = 1'b0;
        w_fmemwb = 1'b0;
        w_dcf    = 1'b0;
        w_r1     = 1'b0;
        w_run    = 1'b0;
        if (RST) begin
            {w_pc, w_ifid, w_idex, w_exmem, w_memwb} = '0;
            {w_fifid, w_fidex, w_fexmem, w_fmemwb} = '1;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (bus.halt_wb) begin
                        w_next = HFLUSH;
                        w_r1   = 1'b1;
                        {w_pc, w_ifid, w_idex,
                         w_exmem, w_memwb} = '0;
                        w_fmemwb = 1'b1;
                    end else if (w_dmiss) begin
                        w_next = DSTALL;
                        {w_pc, w_ifid, w_idex, w_exmem} = '0;
                        w_fmemwb = 1'b1;
                    end else begin
                        w_run = 1'b1;
                    end
                end
                DSTALL: begin
                    if (!bus.dhit) begin
                        {w_pc, w_ifid, w_idex, w_exmem} = '0;
                        w_fmemwb = 1'b1;
                    end else begin
                        w_run  = 1'b1;
                        w_next = RUN;
                    end
                end
                HFLUSH: begin
                    {w_pc, w_ifid, w_idex, w_exmem, w_memwb} = '0;
                    w_dcf = 1'b1;
                    if (bus.flush_done) w_next = HALTED;
                end
                HALTED: begin
                    {w_pc, w_ifid, w_idex, w_exmem, w_memwb} = '0;
                end
                default: w_next = RUN;
            endcase
            // Pipeline advancing: control hazards in priority order.
            if (w_run) begin
                if (bus.branch_taken_ex) begin
                    w_fifid = 1'b1;
                    w_fidex = 1'b1;
                end else if (w_loaduse) begin
                    w_pc    = 1'b0;
                    w_ifid  = 1'b0;
                    w_fidex = 1'b1;
                end else if (bus.jump_id) begin
                    w_fifid = 1'b1;
                end else if (bus.imemREN && !bus.ihit) begin
                    w_pc    = 1'b0;
                    w_fifid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == HFLUSH && bus.flush_done)
                r_halt <= 1'b1;
        end
    end

    assign w_inc = ((r_state == RUN) || (r_state == DSTALL))
                 && !w_r1 && !w_pc && !RST;

    stall_counter #(.CNT_W(CNT_W)) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_inc),
        .count (bus.stall_count)
    );

    assign bus.pc_en        = w_pc;
    assign bus.ifid_en      = w_ifid;
    assign bus.idex_en      = w_idex;
    assign bus.exmem_en     = w_exmem;
    assign bus.memwb_en     = w_memwb;
    assign bus.ifid_flush   = w_fifid;
    assign bus.idex_flush   = w_fidex;
    assign bus.exmem_flush  = w_fexmem;
    assign bus.memwb_flush  = w_fmemwb;
    assign bus.dcache_flush = w_dcf;
    assign bus.halt         = r_halt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with a 4-bit
// stall counter so saturation is reachable.
module tb_hazard_sequencer;
    import cpu_types_pkg::*;

    localparam int CW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    hazard_sequencer_if #(.CNT_W(CW), .REG_W(5)) bus ();

    hazard_sequencer #(.CNT_W(CW), .REG_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Order: pc, ifid, idex, exmem, memwb
    function automatic logic [4:0] ens();
        return {bus.pc_en, bus.ifid_en, bus.idex_en,
                bus.exmem_en, bus.memwb_en};
    endfunction

    // Order: ifid, idex, exmem, memwb
    function automatic logic [3:0] fls();
        return {bus.ifid_flush, bus.idex_flush,
                bus.exmem_flush, bus.memwb_flush};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.ihit = 1'b1;
        bus.imemREN = 1'b1;
        bus.dhit = 1'b0;
        bus.dmemREN_mem = 1'b0;
        bus.dmemWEN_mem = 1'b0;
        bus.memread_ex = 1'b0;
        bus.rt_ex = '0;
        bus.rs_id = '0;
        bus.rt_id = '0;
        bus.branch_taken_ex = 1'b0;
        bus.jump_id = 1'b0;
        bus.halt_wb = 1'b0;
        bus.flush_done = 1'b0;
    endtask

    initial begin
        idle();
        // Reset in progress
        #1;
        chk("rst_ens", 32'(ens()), 32'b00000);
        chk("rst_fls", 32'(fls()), 32'b1111);
        chk("rst_dcf", 32'(bus.dcache_flush), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_state", 32'(dut.r_state), 32'(RUN));
        chk("rst_cnt", 32'(bus.stall_count), 32'd0);
        chk("rst_halt", 32'(bus.halt), 32'd0);
        chk("run_ens", 32'(ens()), 32'b11111);
        chk("run_fls", 32'(fls()), 32'b0000);

        // Load-use on rs
        bus.memread_ex = 1'b1;
        bus.rt_ex = 5'd5;
        bus.rs_id = 5'd5;
        #1;
        chk("lu_ens", 32'(ens()), 32'b00111);
        chk("lu_fls", 32'(fls()), 32'b0100);
        tick();
        chk("lu_cnt", 32'(bus.stall_count), 32'd1);
        // rt_ex = 0 never stalls
        bus.rt_ex = 5'd0;
        bus.rs_id = 5'd0;
        #1;
        chk("lu0_ens", 32'(ens()), 32'b11111);
        chk("lu0_fls", 32'(fls()), 32'b0000);
        tick();
        chk("lu0_cnt", 32'(bus.stall_count), 32'd1);
        // Load-use on rt
        bus.rt_ex = 5'd9;
        bus.rt_id = 5'd9;
        bus.rs_id = 5'd3;
        #1;
        chk("lurt_ens", 32'(ens()), 32'b00111);
        tick();
        chk("lurt_cnt", 32'(bus.stall_count), 32'd2);
        idle();

        // Dcache miss, 3 cycles
        bus.dmemREN_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dm_ens", 32'(ens()), 32'b00001);
            chk("dm_fls", 32'(fls()), 32'b0001);
            tick();
            chk("dm_state", 32'(dut.r_state), 32'(DSTALL));
        end
        bus.dhit = 1'b1;
        #1;
        chk("dh_ens", 32'(ens()), 32'b11111);
        chk("dh_fls", 32'(fls()), 32'b0000);
        tick();
        chk("dh_state", 32'(dut.r_state), 32'(RUN));
        chk("dh_cnt", 32'(bus.stall_count), 32'd5);
        idle();

        // Branch beats load-use and imiss
        bus.branch_taken_ex = 1'b1;
        bus.memread_ex = 1'b1;
        bus.rt_ex = 5'd5;
        bus.rs_id = 5'd5;
        bus.ihit = 1'b0;
        #1;
        chk("br_ens", 32'(ens()), 32'b11111);
        chk("br_fls", 32'(fls()), 32'b1100);
        tick();
        chk("br_cnt", 32'(bus.stall_count), 32'd5);
        idle();

        // Jump with dmiss: dmiss first
        bus.jump_id = 1'b1;
        bus.dmemWEN_mem = 1'b1;
        #1;
        chk("jd_ens", 32'(ens()), 32'b00001);
        chk("jd_fls", 32'(fls()), 32'b0001);
        tick();
        chk("jd_state", 32'(dut.r_state), 32'(DSTALL));
        bus.dhit = 1'b1;
        #1;
        chk("jh_ens", 32'(ens()), 32'b11111);
        chk("jh_fls", 32'(fls()), 32'b1000);
        tick();
        chk("jh_state", 32'(dut.r_state), 32'(RUN));
        chk("jh_cnt", 32'(bus.stall_count), 32'd6);
        idle();

        // Icache miss: counter saturates at 15
        bus.ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("im_ens", 32'(ens()), 32'b01111);
            chk("im_fls", 32'(fls()), 32'b1000);
            tick();
        end
        chk("im_sat", 32'(bus.stall_count), 32'd15);
        idle();

        // Halt drain
        bus.halt_wb = 1'b1;
        #1;
        chk("hw_ens", 32'(ens()), 32'b00000);
        chk("hw_fls", 32'(fls()), 32'b0001);
        tick();
        bus.halt_wb = 1'b0;
        chk("hf_state", 32'(dut.r_state), 32'(HFLUSH));
        for (int i = 0; i < 4; i++) begin
            bus.flush_done = (i == 3);
            #1;
            chk("hf_dcf", 32'(bus.dcache_flush), 32'd1);
            chk("hf_ens", 32'(ens()), 32'b00000);
            chk("hf_fls", 32'(fls()), 32'b0000);
            chk("hf_halt", 32'(bus.halt), 32'd0);
            tick();
        end
        bus.flush_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.halt_wb = i[0];
            bus.dmemREN_mem = i[1];
            #1;
            chk("hd_state", 32'(dut.r_state), 32'(HALTED));
            chk("hd_halt", 32'(bus.halt), 32'd1);
            chk("hd_ens", 32'(ens()), 32'b00000);
            chk("hd_dcf", 32'(bus.dcache_flush), 32'd0);
            tick();
        end
        idle();

        // Reset mid-HFLUSH
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("r2_state", 32'(dut.r_state), 32'(RUN));
        chk("r2_halt", 32'(bus.halt), 32'd0);
        chk("r2_cnt", 32'(bus.stall_count), 32'd0);
        bus.ihit = 1'b0;
        tick();
        chk("r2_cnt1", 32'(bus.stall_count), 32'd1);
        idle();
        bus.halt_wb = 1'b1;
        tick();
        bus.halt_wb = 1'b0;
        chk("h2_state", 32'(dut.r_state), 32'(HFLUSH));
        tick();
        RST = 1'b1;
        #1;
        chk("h2_rens", 32'(ens()), 32'b00000);
        chk("h2_rfls", 32'(fls()), 32'b1111);
        chk("h2_rdcf", 32'(bus.dcache_flush), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("h2_state2", 32'(dut.r_state), 32'(RUN));
        chk("h2_halt", 32'(bus.halt), 32'd0);
        chk("h2_cnt", 32'(bus.stall_count), 32'd0);
        chk("h2_ens", 32'(ens()), 32'b11111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
